muldiv_unit: RTL
================

# muldiv_unit

Iterative RV32M multiply/divide unit sitting beside the integer ALU in the execute stage. It consumes the same two ALU operands (rs1/rs2 values) plus funct3, and produces the 32-bit result written back through the Mem2Reg path. While it computes, its busy output drives the datapath stall so that PC and register-file writes are held. The unit is a radix-2 shift-add / shift-subtract engine: one bit per clock, with a fast path for the RISC-V divide special cases.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported and verified.
- iCLK  input  1  system clock; all state updates on the rising edge.
- iRST  input  1  asynchronous, active-low reset.
- iStart  input  1  request; sampled only while oBusy=0.
- iFunct3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- iA  input  WIDTH  rs1 operand (multiplicand / dividend).
- iB  input  WIDTH  rs2 operand (multiplier / divisor).
- oResult  output  WIDTH  result; held stable from oDone until the next accepted iStart.
- oBusy  output  1  high from the cycle after acceptance through the cycle before oDone; stall request.
- oDone  output  1  one-cycle pulse; oResult is valid in the same cycle.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + iStart=1:
  - Latch funct3, operand signs, and the absolute operand values. Signedness per op: MULH both signed, MULHSU only iA signed, MULHU/DIVU/REMU unsigned.
  - Clear the 64-bit accumulator and the 5-bit counter, then go to CALC.
  - Exception: a divide special case goes straight to DONE.
- Divide special cases, detected at acceptance:
  - Divisor = 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return iA.
  - DIV/REM with iA=0x80000000 and iB=0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
- CALC, one iteration per cycle:
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the high half of the accumulator; then shift right 1.
  - Divide: shift the {remainder, quotient} pair left 1; trial-subtract the divisor; if the result is non-negative, keep it and set quotient bit 0.
  - Counter wraps 31→0; the wrap moves to FIX.
- FIX:
  - Apply two's-complement negation where the latched signs require it. Product is negated if signA XOR signB (signed ops only); quotient likewise; remainder takes the dividend's sign.
  - Select the output: MUL = product[31:0]; MULH* = product[63:32]; DIV* = quotient; REM* = remainder.
  - Register oResult, then go to DONE.
- DONE: oDone=1 for exactly one cycle, then IDLE; a new iStart in DONE is accepted (back-to-back).
- iStart while oBusy=1 is ignored; operand/funct3 changes during CALC have no effect.
- Reset (iRST=0, any state, including mid-CALC) immediately gives: state IDLE, oResult=0, oBusy=0, oDone=0, accumulator and counter cleared. There is no partial result.

## Timing
- Reset values: oResult=0x00000000, oBusy=0, oDone=0.
- Normal op, with iStart accepted on edge 0:
  - CALC occupies cycles 1–32 and FIX is cycle 33.
  - oDone=1 and oResult valid in cycle 34 (latency 34).
  - oBusy=1 in cycles 1–33.
- Special-case divide: oDone=1 in cycle 1; oBusy never asserts.
- Throughput: one op per 34 cycles with back-to-back starts issued in DONE.
- oDone and oBusy are never high in the same cycle.
- oResult changes only on the FIX→DONE edge, on special-case acceptance, or on reset.

## Test plan
- MUL 7×(−3), and MULH 0x80000000×0x80000000 → 0xFFFFFFEB at cycle 34; then 0x40000000; oBusy high for exactly 33 cycles.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/−1 → 0x80000000; REM of the same operands → 0.
  - Each special case gives oDone in cycle 1 with oBusy=0.
- Stall and back-to-back:
  - Pulse iStart mid-CALC with changed operands → ignored; the original result is delivered.
  - Issue iStart in the DONE cycle → second result arrives 34 cycles later.
- Pull iRST low at cycle 15 of a DIV → outputs 0 and state IDLE immediately. After release, a fresh MUL 3×4 returns 12 at latency 34.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add / shift-subtract, one bit per clock.
// Divide-by-zero and signed-overflow divides are resolved at acceptance and never enter CALC.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic [2:0]       iFunct3,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic [WIDTH-1:0] oResult,
    output logic             oBusy,
    output logic             oDone
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               in_is_div, in_signed_a, in_signed_b, in_neg_a, in_neg_b;
    logic [WIDTH-1:0]   in_abs_a, in_abs_b;
    logic               div_zero, div_ovf;
    logic [WIDTH:0]     mul_sum, div_rem, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Operand decode at acceptance
    assign in_is_div   = iFunct3[2];
    assign in_signed_a = !(iFunct3 == 3'b011 || iFunct3 == 3'b101 || iFunct3 == 3'b111);
    assign in_signed_b = (iFunct3 == 3'b000 || iFunct3 == 3'b001 ||
                          iFunct3 == 3'b100 || iFunct3 == 3'b110);
    assign in_neg_a    = in_signed_a & iA[WIDTH-1];
    assign in_neg_b    = in_signed_b & iB[WIDTH-1];
    assign in_abs_a    = in_neg_a ? -iA : iA;
    assign in_abs_b    = in_neg_b ? -iB : iB;
    assign div_zero    = in_is_div && (iB == '0);
    assign div_ovf     = in_is_div && !iFunct3[0] && (iA == {1'b1, {(WIDTH-1){1'b0}}}) && (iB == '1);

    // Multiply step: conditional add into the high half, carry shifts in from the top
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    // Divide step: remainder shifted left with the next dividend bit, kept one bit wide extra
    assign div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_rem - {1'b0, mcand_q};

    assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    assign quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) state_d = IDLE;
                if (iStart) begin
                    op_d     = iFunct3;
                    sign_a_d = in_neg_a;
                    sign_b_d = in_neg_b;
                    // Divide keeps the dividend in the quotient half so it shifts out bit by bit
                    acc_d    = in_is_div ? {{WIDTH{1'b0}}, in_abs_a} : '0;
                    mcand_d  = in_is_div ? in_abs_b : in_abs_a;
                    mplier_d = in_abs_b;
                    cnt_d    = '0;
                    state_d  = CALC;
                    if (div_zero) begin
                        result_d = iFunct3[1] ? iA : '1;
                        state_d  = DONE;
                    end else if (div_ovf) begin
                        result_d = iFunct3[1] ? '0 : iA;
                        state_d  = DONE;
                    end
                end
            end
            CALC: begin
                if (op_q[2]) begin
                    if (!div_diff[WIDTH])
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                case (op_q)
                    3'b000:                 result_d = prod_fix[WIDTH-1:0];
                    3'b001, 3'b010, 3'b011: result_d = prod_fix[2*WIDTH-1:WIDTH];
                    3'b100, 3'b101:         result_d = quo_fix;
                    default:                result_d = rem_fix;
                endcase
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign oResult = result_q;
    assign oBusy   = (state_q == CALC) || (state_q == FIX);
    assign oDone   = (state_q == DONE);

endmodule
